// File: rtl/lcv_alu_arbiter.sv
// Purpose: round-robin share of one registered ALU among NUM_REQ requesters, results tagged with requester ID.
// Latency: handshake edge -> ALU result captured one edge later -> rsp_valid after that capture edge.
// Backpressure: 2-entry response FIFO; issue is credit-gated so in-flight plus queued results never exceed 2.
module lcv_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*8-1:0]     req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         alu_inp_a,
    output logic [WIDTH-1:0]         alu_inp_b_0,
    output logic [WIDTH-1:0]         alu_inp_b_1,
    output logic                     alu_inp_b_sel,
    output logic [7:0]               alu_inp_op,
    input  logic [WIDTH-1:0]         alu_outp_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [ID_W-1:0]  grant;
    logic             grant_vld;
    logic             issue_ok;
    logic             handshake;
    logic             inflight;
    logic [ID_W-1:0]  inflight_id;
    logic [1:0]       fifo_cnt;
    logic             fifo_wr_ptr;
    logic             fifo_rd_ptr;
    logic [ID_W-1:0]  fifo_id   [2];
    logic [WIDTH-1:0] fifo_data [2];
    logic             pop;
    logic [2:0]       occupancy;
    int               idx;

    // The B1 path of the ALU is never used.
    assign alu_inp_b_1   = '0;
    assign alu_inp_b_sel = 1'b0;

    // Credit: result slots already claimed, minus the one leaving this cycle.
    assign pop       = rsp_valid & rsp_ready;
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign issue_ok  = (occupancy - {2'b00, pop}) < 3'd2;

    // Round-robin search starting at rr_ptr for the first valid requester.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    // Reset gates acceptance so nothing is issued while rst is low.
    assign handshake  = grant_vld & issue_ok & rst;
    assign rr_ptr_nxt = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

    // One-hot accept towards the granted requester only.
    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Steer granted operands to the ALU; idle cycles issue ZERO with cleared operands.
    always_comb begin
        alu_inp_op  = 8'h80;
        alu_inp_a   = '0;
        alu_inp_b_0 = '0;
        if (handshake) begin
            alu_inp_op  = req_op[int'(grant) * 8 +: 8];
            alu_inp_a   = req_a[int'(grant) * WIDTH +: WIDTH];
            alu_inp_b_0 = req_b[int'(grant) * WIDTH +: WIDTH];
        end
    end

    // Arbitration pointer and in-flight tracking for the op issued last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_id <= '0;
        end else begin
            if (handshake) begin
                rr_ptr <= rr_ptr_nxt;
            end
            inflight    <= handshake;
            inflight_id <= grant;
        end
    end

    // Response FIFO: capture the ALU result of the in-flight op, pop on consumer accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_cnt    <= 2'd0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                fifo_id[e]   <= '0;
                fifo_data[e] <= '0;
            end
        end else begin
            if (inflight) begin
                fifo_id[fifo_wr_ptr]   <= inflight_id;
                fifo_data[fifo_wr_ptr] <= alu_outp_data;
                fifo_wr_ptr            <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({inflight, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rsp_valid = (fifo_cnt != 2'd0);
    assign rsp_id    = fifo_id[fifo_rd_ptr];
    assign rsp_data  = fifo_data[fifo_rd_ptr];

endmodule

// File: tb/tb_lcv_alu_arbiter.sv
module tb_lcv_alu_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   alu_inp_a, alu_inp_b_0, alu_inp_b_1;
    logic           alu_inp_b_sel;
    logic [7:0]     alu_inp_op;
    logic [W-1:0]   alu_outp_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;

    logic [7:0]     op_v [N];
    logic [W-1:0]   a_v  [N];
    logic [W-1:0]   b_v  [N];

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] data;
        bit           dc;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int npop   = 0;

    always #5 clk = ~clk;

    lcv_alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_inp_a(alu_inp_a), .alu_inp_b_0(alu_inp_b_0), .alu_inp_b_1(alu_inp_b_1),
        .alu_inp_b_sel(alu_inp_b_sel), .alu_inp_op(alu_inp_op),
        .alu_outp_data(alu_outp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_op[i*8 +: 8] = op_v[i];
            req_a[i*W +: W]  = a_v[i];
            req_b[i*W +: W]  = b_v[i];
        end
    end

    function automatic logic [W-1:0] alu_f(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            8'h01:   return a + b;
            8'h02:   return a - b;
            8'h04:   return (a < b) ? 32'd1 : 32'd0;
            8'h08:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8'h10:   return a & b;
            8'h20:   return a | b;
            8'h40:   return a ^ b;
            8'h80:   return '0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Registered ALU environment: result valid one cycle after issue.
    always @(posedge clk)
        alu_outp_data <= alu_f(alu_inp_op, alu_inp_a, alu_inp_b_sel ? alu_inp_b_1 : alu_inp_b_0);

    // Scoreboard: pop/compare on response handshake, push expected on request handshake.
    always @(negedge clk) begin
        logic [N-1:0] hs;
        exp_t e;
        if (rst === 1'b1) begin
            hs = req_valid & req_ready;
            if (rsp_valid && rsp_ready) begin
                npop++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rsp: got id=%0d data=%h, required no response", rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    if (rsp_id !== e.id || (!e.dc && rsp_data !== e.data)) begin
                        errors++;
                        $display("FAIL sb_rsp: got id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
                    end
                end
            end
            if (hs != '0) begin
                checks++;
                if ($countones(hs) != 1 || sb.size() >= 2) begin
                    errors++;
                    $display("FAIL credit_onehot: got ready=%b pending=%0d, required one-hot and pending<2", hs, sb.size());
                end
                for (int i = 0; i < N; i++) begin
                    if (hs[i]) begin
                        e.id   = 2'(i);
                        e.data = alu_f(op_v[i], a_v[i], b_v[i]);
                        e.dc   = ($countones(op_v[i]) != 1);
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        req_valid = '0;
        step();
        @(posedge clk);
        #3 rst = 1'b1;
        step();
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got pending=%0d rsp_valid=%b, required 0/0", name, sb.size(), rsp_valid);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            op_v[i] = 8'h01; a_v[i] = 32'(i); b_v[i] = 32'd1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b id=%0d d=%h, required 0 0 0", rsp_valid, rsp_id, rsp_data);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 0000", req_ready);
        end
        checks++;
        if (alu_inp_op !== 8'h80 || alu_inp_a !== '0 || alu_inp_b_0 !== '0 || alu_inp_b_1 !== '0 || alu_inp_b_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu_idle: got op=%h a=%h b0=%h b1=%h sel=%b, required 80 0 0 0 0",
                     alu_inp_op, alu_inp_a, alu_inp_b_0, alu_inp_b_1, alu_inp_b_sel);
        end
        req_valid = '0;
        @(posedge clk);
        #3 rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit got;
        op_v[2] = 8'h01; a_v[2] = 32'd5; b_v[2] = 32'd7;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || alu_inp_a !== 32'd5 || alu_inp_b_0 !== 32'd7 || alu_inp_op !== 8'h01) begin
            errors++;
            $display("FAIL single_issue: got ready=%b a=%0d b=%0d op=%h, required 0100 5 7 01",
                     req_ready, alu_inp_a, alu_inp_b_0, alu_inp_op);
        end
        step();
        req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 3 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        checks++;
        if (!got || rsp_id !== 2'd2 || rsp_data !== 32'd12) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%0d d=%0d, required 1 2 12", got, rsp_id, rsp_data);
        end
        step();
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL single_rr_ptr: got ready=%b, required 1000", req_ready);
        end
        step();
        wait_drain("single");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_r;
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_v[i] = 8'h02; a_v[i] = 32'd100; b_v[i] = 32'(i);
        end
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_r = 4'b0001 << (c % 4);
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b, required %b", c, req_ready, exp_r);
            end
            step();
        end
        wait_drain("rr");
    endtask

    task automatic test_backpressure();
        int  acc;
        bit  hs, have_head;
        logic [1:0]   h_id;
        logic [W-1:0] h_data;
        rsp_ready = 1'b0;
        op_v[1] = 8'h40; a_v[1] = 32'hA5A5_0000; b_v[1] = 32'd1;
        req_valid = 4'b0010;
        acc = 0; have_head = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            hs = req_ready[1];
            if (hs) acc++;
            if (rsp_valid) begin
                if (!have_head) begin
                    have_head = 1'b1; h_id = rsp_id; h_data = rsp_data;
                end else begin
                    checks++;
                    if (rsp_id !== h_id || rsp_data !== h_data) begin
                        errors++;
                        $display("FAIL bp_head_stable: got id=%0d d=%h, required id=%0d d=%h", rsp_id, rsp_data, h_id, h_data);
                    end
                end
            end
            step();
            if (hs) b_v[1] = b_v[1] + 32'd1;
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accept_count: got %0d, required 2", acc);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            hs = req_ready[1];
            if (hs) acc++;
            step();
            if (hs) b_v[1] = b_v[1] + 32'd1;
        end
        checks++;
        if (acc < 6) begin
            errors++;
            $display("FAIL bp_resume: got %0d accepts, required at least 6", acc);
        end
        wait_drain("bp");
    endtask

    task automatic test_pop_capture();
        int p0;
        p0 = npop;
        rsp_ready = 1'b0;
        op_v[0] = 8'h01; a_v[0] = 32'd1; b_v[0] = 32'd2;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL pc_first: got %b, required 0001", req_ready);
        end
        step();
        op_v[0] = 8'h10; a_v[0] = 32'hF0; b_v[0] = 32'h3C;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL pc_second: got %b, required 0001", req_ready);
        end
        step();
        rsp_ready = 1'b1;
        op_v[0] = 8'h20; a_v[0] = 32'h100; b_v[0] = 32'h2;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL pc_same_cycle: got v=%b ready=%b, required 1 0001", rsp_valid, req_ready);
        end
        step();
        wait_drain("pc");
        checks++;
        if (npop - p0 != 3) begin
            errors++;
            $display("FAIL pc_count: got %0d responses, required 3", npop - p0);
        end
    endtask

    task automatic test_compare();
        logic [W-1:0] expv [2];
        int got;
        expv[0] = 32'd1; expv[1] = 32'd0;
        rsp_ready = 1'b1;
        op_v[3] = 8'h08; a_v[3] = 32'hFFFF_FFFF; b_v[3] = 32'd1;
        req_valid = 4'b1000;
        @(negedge clk);
        step();
        op_v[3] = 8'h04;
        @(negedge clk);
        step();
        req_valid = '0;
        got = 0;
        for (int c = 0; c < 8 && got < 2; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== expv[got] || rsp_id !== 2'd3) begin
                    errors++;
                    $display("FAIL cmp_rsp%0d: got id=%0d d=%0d, required id=3 d=%0d", got, rsp_id, rsp_data, expv[got]);
                end
                got++;
            end
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL cmp_count: got %0d responses, required 2", got);
        end
        step();
        wait_drain("cmp");
    endtask

    task automatic test_odd_ops();
        logic [N-1:0] pend, hs;
        op_v[0] = 8'h00; a_v[0] = 32'd9;  b_v[0] = 32'd9;
        op_v[1] = 8'h03; a_v[1] = 32'd4;  b_v[1] = 32'd4;
        op_v[2] = 8'h80; a_v[2] = 32'd5;  b_v[2] = 32'd6;
        op_v[3] = 8'h10; a_v[3] = 32'hFF; b_v[3] = 32'h0F;
        pend = '1;
        req_valid = pend;
        for (int c = 0; c < 12 && pend != '0; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            step();
            pend = pend & ~hs;
            req_valid = pend;
        end
        checks++;
        if (pend != '0) begin
            errors++;
            $display("FAIL odd_accept: got pending=%b, required 0000", pend);
        end
        wait_drain("odd");
    endtask

    task automatic test_reset_mid();
        bit got;
        rsp_ready = 1'b0;
        op_v[1] = 8'h01; a_v[1] = 32'd50; b_v[1] = 32'd1;
        req_valid = 4'b0010;
        repeat (3) step();
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL rmid_immediate: got v=%b ready=%b, required 0 0000", rsp_valid, req_ready);
        end
        sb.delete();
        for (int i = 0; i < N; i++) begin
            op_v[i] = 8'h01; a_v[i] = 32'(i + 10); b_v[i] = 32'd1;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        step();
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_grant: got %b, required 0001", req_ready);
        end
        step();
        req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        checks++;
        if (!got || rsp_id !== 2'd0 || rsp_data !== 32'd11) begin
            errors++;
            $display("FAIL rmid_first_rsp: got v=%b id=%0d d=%0d, required 1 0 11", got, rsp_id, rsp_data);
        end
        step();
        wait_drain("rmid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_v[i] = 8'h80; a_v[i] = '0; b_v[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_pop_capture();
        test_compare();
        test_odd_ops();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_empty: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
